complex_operand_fifo: RTL and testbench

- Operand staging buffer that sits directly upstream of the complex multiply-add stage.
- Accepts one complex operand pair (x, y) per beat and optionally conjugates y.
- Packs each entry into the 4x64-bit operand bundle the multiply stage consumes.
- Decouples the producer from multiplier backpressure via a parameterised FIFO, with flush and occupancy reporting.

---
 rtl/complex_operand_fifo.sv | 76 +++++++
 tb/tb_complex_operand_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/complex_operand_fifo.sv
// Operand staging FIFO in front of the complex multiply-add stage.
// Each entry holds one (x, y) pair, optionally with y conjugated at push time,
// packed as {x_re, x_im, y_re, y_im}. Full/empty come from the occupancy count.
module complex_operand_fifo #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [63:0]           x_re_i,
    input  logic [63:0]           x_im_i,
    input  logic [63:0]           y_re_i,
    input  logic [63:0]           y_im_i,
    input  logic                  conj_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    output logic [3:0][63:0]      operands_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [CNT_W-1:0]      level_o,
    output logic                  busy_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [3:0][63:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Conjugation is a pure sign flip of the imaginary part, so NaN, inf and
    // zero all pass through with only bit 63 toggled.
    function automatic logic [63:0] conj_im(input logic [63:0] im, input logic conj);
        return {im[63] ^ conj, im[62:0]};
    endfunction

    // Flush wins over both handshakes: anything offered in the flush cycle is dropped.
    always_comb begin
        in_ready_o  = (count != CNT_W'(DEPTH));
        out_valid_o = (count != '0);
        push        = in_valid_i && in_ready_o && !flush_i;
        pop         = out_valid_o && out_ready_i && !flush_i;
        operands_o  = mem[rd_ptr];
        level_o     = count;
        busy_o      = (count != '0);
    end

    // Storage is data only and carries no reset; it is read only while count says valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {x_re_i, x_im_i, y_re_i, conj_im(y_im_i, conj_i)};
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_complex_operand_fifo.sv
// Directed bench for complex_operand_fifo (DEPTH=4).
module tb_complex_operand_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk_i;
    logic             rst_ni;
    logic [63:0]      x_re_i, x_im_i, y_re_i, y_im_i;
    logic             conj_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             flush_i;
    logic [3:0][63:0] operands_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CNT_W-1:0] level_o;
    logic             busy_o;

    int tests = 0;
    int fails = 0;

    complex_operand_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .x_re_i      (x_re_i),
        .x_im_i      (x_im_i),
        .y_re_i      (y_re_i),
        .y_im_i      (y_im_i),
        .conj_i      (conj_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .operands_o  (operands_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .level_o     (level_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [63:0] xr, input logic [63:0] xi,
                         input logic [63:0] yr, input logic [63:0] yi,
                         input logic cj, input logic vld);
        x_re_i = xr; x_im_i = xi; y_re_i = yr; y_im_i = yi;
        conj_i = cj; in_valid_i = vld;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        drive(64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        #1;
        chk("rst_in_ready",  64'(in_ready_o),  64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_level",     64'(level_o),     64'd0);
        chk("rst_busy",      64'(busy_o),      64'd0);
        step();
        step();
        rst_ni = 1'b1;

        // Scenario 1: single pair, no conjugation
        out_ready_i = 1'b1;
        drive(64'h3FF0000000000000, 64'h4000000000000000,
              64'h3FE0000000000000, 64'hBFF0000000000000, 1'b0, 1'b1);
        step();
        in_valid_i = 1'b0;
        chk("s1_valid", 64'(out_valid_o), 64'd1);
        chk("s1_x_re",  operands_o[3], 64'h3FF0000000000000);
        chk("s1_x_im",  operands_o[2], 64'h4000000000000000);
        chk("s1_y_re",  operands_o[1], 64'h3FE0000000000000);
        chk("s1_y_im",  operands_o[0], 64'hBFF0000000000000);
        chk("s1_level", 64'(level_o), 64'd1);
        chk("s1_busy",  64'(busy_o),  64'd1);
        step();
        chk("s1_level_after_pop", 64'(level_o), 64'd0);
        chk("s1_valid_after_pop", 64'(out_valid_o), 64'd0);

        // Scenario 2: conjugation, including a NaN imaginary part
        out_ready_i = 1'b0;
        drive(64'h3FF0000000000000, 64'h4000000000000000,
              64'h3FE0000000000000, 64'hBFF0000000000000, 1'b1, 1'b1);
        step();
        in_valid_i = 1'b0;
        chk("s2_y_im_conj", operands_o[0], 64'h3FF0000000000000);
        chk("s2_y_re_kept", operands_o[1], 64'h3FE0000000000000);
        chk("s2_x_im_kept", operands_o[2], 64'h4000000000000000);
        out_ready_i = 1'b1;
        step();
        chk("s2_level_pop", 64'(level_o), 64'd0);
        out_ready_i = 1'b0;
        drive(64'h3FF0000000000000, 64'h4000000000000000,
              64'h3FE0000000000000, 64'h7FF8000000000000, 1'b1, 1'b1);
        step();
        in_valid_i = 1'b0;
        chk("s2_nan_conj", operands_o[0], 64'hFFF8000000000000);
        out_ready_i = 1'b1;
        step();
        chk("s2_drained", 64'(level_o), 64'd0);

        // Scenario 3 + 5: fill to full, hold the 5th, concurrent pop at full
        out_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(64'(i), 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
            step();
        end
        chk("s3_full_ready", 64'(in_ready_o), 64'd0);
        chk("s3_full_level", 64'(level_o),    64'd4);
        drive(64'd5, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        step();
        step();
        chk("s3_held_level", 64'(level_o),    64'd4);
        chk("s3_head_1",     operands_o[3],   64'd1);
        out_ready_i = 1'b1;
        step();
        chk("s5_level_3",    64'(level_o),    64'd3);
        chk("s5_ready_back", 64'(in_ready_o), 64'd1);
        chk("s3_head_2",     operands_o[3],   64'd2);
        step();
        in_valid_i = 1'b0;
        chk("s3_head_3",     operands_o[3],   64'd3);
        chk("s3_level_3b",   64'(level_o),    64'd3);
        step();
        chk("s3_head_4",     operands_o[3],   64'd4);
        step();
        chk("s3_head_5",     operands_o[3],   64'd5);
        chk("s3_level_1",    64'(level_o),    64'd1);
        step();
        chk("s3_empty",      64'(out_valid_o), 64'd0);

        // Scenario 4: sustained push+pop at level 2
        out_ready_i = 1'b0;
        drive(64'd10, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        step();
        drive(64'd11, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        step();
        out_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(64'(12 + k), 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
            chk($sformatf("s4_head_%0d", k),  operands_o[3], 64'(10 + k));
            chk($sformatf("s4_level_%0d", k), 64'(level_o), 64'd2);
            step();
        end
        in_valid_i = 1'b0;
        chk("s4_head_20", operands_o[3], 64'd20);
        step();
        chk("s4_head_21", operands_o[3], 64'd21);
        step();
        chk("s4_empty", 64'(level_o), 64'd0);

        // Scenario 6a: flush at level 3 with push and pop offered
        out_ready_i = 1'b0;
        for (int i = 30; i <= 32; i++) begin
            drive(64'(i), 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
            step();
        end
        chk("s6_level_3", 64'(level_o), 64'd3);
        drive(64'd33, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        out_ready_i = 1'b1;
        flush_i = 1'b1;
        chk("s6_ready_during_flush", 64'(in_ready_o), 64'd1);
        step();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("s6_flush_level", 64'(level_o),     64'd0);
        chk("s6_flush_valid", 64'(out_valid_o), 64'd0);
        chk("s6_flush_busy",  64'(busy_o),      64'd0);
        drive(64'd40, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
        step();
        in_valid_i = 1'b0;
        chk("s6_post_flush_head",  operands_o[3],  64'd40);
        chk("s6_post_flush_level", 64'(level_o),   64'd1);

        // Scenario 6b: asynchronous reset between clock edges
        #2;
        rst_ni = 1'b0;
        #1;
        chk("s6_async_valid", 64'(out_valid_o), 64'd0);
        chk("s6_async_level", 64'(level_o),     64'd0);
        chk("s6_async_busy",  64'(busy_o),      64'd0);
        chk("s6_async_ready", 64'(in_ready_o),  64'd1);
        step();
        rst_ni = 1'b1;
        step();
        chk("s6_after_reset_level", 64'(level_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
